// File: rtl/secure_reg_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : secure_reg_bank_if
// Purpose  : Core-side config bus bundle for secure_reg_bank: request,
//            violation clear, response and status signals.
// Ports    : none (signal bundle only)
//            master modport - drives requests/viol_clr, observes response
//            slave modport  - the register bank
// Revision : 1.0 - initial release
// ============================================================================
interface secure_reg_bank_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter int TID_WIDTH  = 4,
    parameter int VIOL_CNT_W = 8
);
    localparam int c_aw = $clog2(NUM_REGS);

    logic                  req_valid;
    logic                  req_write;
    logic                  req_lock;
    logic [c_aw-1:0]       req_addr;
    logic [TID_WIDTH-1:0]  req_tid;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  viol_clr;
    logic                  rsp_valid;
    logic                  rsp_err;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [NUM_REGS-1:0]   lock_status;
    logic [VIOL_CNT_W-1:0] viol_count;
    logic                  viol_irq;

    modport master (
        output req_valid, req_write, req_lock, req_addr, req_tid, req_wdata,
               viol_clr,
        input  rsp_valid, rsp_err, rsp_rdata, lock_status, viol_count, viol_irq
    );

    modport slave (
        input  req_valid, req_write, req_lock, req_addr, req_tid, req_wdata,
               viol_clr,
        output rsp_valid, rsp_err, rsp_rdata, lock_status, viol_count, viol_irq
    );
endinterface
`default_nettype wire

// File: rtl/secure_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : secure_reg_bank
// Purpose  : Bank of NUM_REGS secure registers. Each entry carries an owner
//            thread id and an OPEN/OWNED/LOCKED state; the privileged thread
//            PRIV_TID can always reach every entry. Rejected accesses are
//            counted (saturating) and raise a sticky interrupt at a threshold.
//            One request per cycle, fixed one-cycle response.
// Ports    : clk  - clock, rising edge
//            rst  - synchronous reset, active high
//            bus  - secure_reg_bank_if.slave: request, viol_clr, response,
//                   lock_status, viol_count, viol_irq
// Revision : 1.0 - initial release
// ============================================================================
module secure_reg_bank #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 8,
    parameter int TID_WIDTH   = 4,
    parameter int PRIV_TID    = 0,
    parameter int VIOL_CNT_W  = 8,
    parameter int VIOL_THRESH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    secure_reg_bank_if.slave   bus
);
    localparam int                    c_aw         = $clog2(NUM_REGS);
    localparam logic [TID_WIDTH-1:0]  c_priv_tid   = TID_WIDTH'(PRIV_TID);
    localparam logic [VIOL_CNT_W-1:0] c_viol_max   = '1;
    localparam logic [VIOL_CNT_W-1:0] c_viol_thr   = VIOL_CNT_W'(VIOL_THRESH);
    localparam logic [VIOL_CNT_W-1:0] c_viol_one   = VIOL_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_OPEN   = 2'd0,
        ST_OWNED  = 2'd1,
        ST_LOCKED = 2'd2
    } reg_state_e;

    // ------------------------------------------------------------------
    // Register file state
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] data_q  [NUM_REGS];
    logic [DATA_WIDTH-1:0] data_d  [NUM_REGS];
    logic [TID_WIDTH-1:0]  owner_q [NUM_REGS];
    logic [TID_WIDTH-1:0]  owner_d [NUM_REGS];
    reg_state_e            state_q [NUM_REGS];
    reg_state_e            state_d [NUM_REGS];

    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [VIOL_CNT_W-1:0] viol_count_q, viol_count_d;
    logic                  viol_irq_q,   viol_irq_d;

    // ------------------------------------------------------------------
    // Address decode. The one-hot hit vector doubles as the range check:
    // an index at or beyond NUM_REGS matches no entry.
    // ------------------------------------------------------------------
    logic [NUM_REGS-1:0]   w_hit;
    logic                  w_addr_ok;
    reg_state_e            w_sel_state;
    logic [TID_WIDTH-1:0]  w_sel_owner;
    logic [DATA_WIDTH-1:0] w_sel_data;

    always_comb begin
        w_hit       = '0;
        w_sel_state = ST_OPEN;
        w_sel_owner = '0;
        w_sel_data  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.req_addr == c_aw'(i)) begin
                w_hit[i]    = 1'b1;
                w_sel_state = state_q[i];
                w_sel_owner = owner_q[i];
                w_sel_data  = data_q[i];
            end
        end
    end

    assign w_addr_ok = |w_hit;

    // ------------------------------------------------------------------
    // Access check
    // ------------------------------------------------------------------
    logic w_priv;
    logic w_own;
    logic w_ok;
    logic w_accept;
    logic w_reject;

    assign w_priv = (bus.req_tid == c_priv_tid);
    assign w_own  = (bus.req_tid == w_sel_owner);

    always_comb begin
        w_ok = 1'b0;
        if (w_addr_ok) begin
            case (w_sel_state)
                ST_OPEN:   w_ok = 1'b1;
                ST_OWNED:  w_ok = w_own | w_priv;
                ST_LOCKED: w_ok = bus.req_write ? w_priv : (w_own | w_priv);
                default:   w_ok = 1'b0;
            endcase
        end
    end

    assign w_accept = bus.req_valid &  w_ok;
    assign w_reject = bus.req_valid & ~w_ok;

    // ------------------------------------------------------------------
    // Per-register next state
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            data_d[i]  = data_q[i];
            owner_d[i] = owner_q[i];
            state_d[i] = state_q[i];
            if (w_accept && bus.req_write && w_hit[i]) begin
                data_d[i] = bus.req_wdata;
                case (state_q[i])
                    ST_OPEN: begin
                        owner_d[i] = bus.req_tid;
                        state_d[i] = bus.req_lock ? ST_LOCKED : ST_OWNED;
                    end
                    ST_OWNED: begin
                        // Owner is kept even when the privileged thread writes.
                        if (bus.req_lock) begin
                            state_d[i] = ST_LOCKED;
                        end
                    end
                    ST_LOCKED: begin
                        // Only a privileged write gets here; without req_lock
                        // it releases the entry back to the privileged owner.
                        if (!bus.req_lock) begin
                            state_d[i] = ST_OPEN;
                            owner_d[i] = c_priv_tid;
                        end
                    end
                    default: begin
                        state_d[i] = ST_OPEN;
                        owner_d[i] = c_priv_tid;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Response and violation tracking next state
    // ------------------------------------------------------------------
    always_comb begin
        rsp_valid_d  = bus.req_valid;
        rsp_err_d    = w_reject;
        rsp_rdata_d  = (w_accept && !bus.req_write) ? w_sel_data : '0;

        viol_count_d = viol_count_q;
        viol_irq_d   = viol_irq_q;
        if (bus.viol_clr) begin
            // A reject landing on the clear cycle survives as a count of one.
            viol_count_d = w_reject ? c_viol_one : '0;
            viol_irq_d   = w_reject && (c_viol_one >= c_viol_thr);
        end else if (w_reject) begin
            if (viol_count_q != c_viol_max) begin
                viol_count_d = viol_count_q + c_viol_one;
            end
            if (viol_count_d >= c_viol_thr) begin
                viol_irq_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data_q[i]  <= '0;
                owner_q[i] <= c_priv_tid;
                state_q[i] <= ST_OPEN;
            end
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            viol_count_q <= '0;
            viol_irq_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data_q[i]  <= data_d[i];
                owner_q[i] <= owner_d[i];
                state_q[i] <= state_d[i];
            end
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            viol_count_q <= viol_count_d;
            viol_irq_q   <= viol_irq_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_lock
            assign bus.lock_status[g] = (state_q[g] == ST_LOCKED);
        end
    endgenerate

    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.viol_count = viol_count_q;
    assign bus.viol_irq   = viol_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_secure_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_secure_reg_bank
// Purpose  : Self-checking bench for secure_reg_bank (NUM_REGS=6,
//            VIOL_THRESH=4). Expected responses are queued when a request is
//            driven and popped when the response cycle is sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_secure_reg_bank;
    localparam int DW     = 32;
    localparam int NREGS  = 6;
    localparam int TW     = 4;
    localparam int CW     = 8;
    localparam int THRESH = 4;

    logic clk;
    logic rst;

    secure_reg_bank_if #(
        .DATA_WIDTH (DW),
        .NUM_REGS   (NREGS),
        .TID_WIDTH  (TW),
        .VIOL_CNT_W (CW)
    ) bus ();

    secure_reg_bank #(
        .DATA_WIDTH  (DW),
        .NUM_REGS    (NREGS),
        .TID_WIDTH   (TW),
        .PRIV_TID    (0),
        .VIOL_CNT_W  (CW),
        .VIOL_THRESH (THRESH)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model: state 0=open, 1=owned, 2=locked
    logic [DW-1:0] m_data  [0:7];
    logic [TW-1:0] m_owner [0:7];
    int            m_state [0:7];
    int            m_cnt;
    logic          m_irq;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_data[i]  = '0;
            m_owner[i] = '0;
            m_state[i] = 0;
        end
        m_cnt = 0;
        m_irq = 1'b0;
    endtask

    // One bus cycle: drive on the falling edge, predict, sample 1ns after the
    // rising edge.
    task automatic cycle(input logic r, input logic v, input logic w, input logic lk,
                         input logic [2:0] a, input logic [TW-1:0] t,
                         input logic [DW-1:0] d, input logic clr);
        exp_t          e;
        exp_t          got;
        logic          ok;
        logic          priv;
        logic          own;
        logic [NREGS-1:0] lk_exp;
        @(negedge clk);
        rst           = r;
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_lock  = lk;
        bus.req_addr  = a;
        bus.req_tid   = t;
        bus.req_wdata = d;
        bus.viol_clr  = clr;
        if (r) begin
            model_reset();
        end else begin
            ok = 1'b0;
            if (v) begin
                priv = (t == 0);
                if (a < NREGS) begin
                    own = (t == m_owner[a]);
                    if (m_state[a] == 0)      ok = 1'b1;
                    else if (m_state[a] == 1) ok = own || priv;
                    else                      ok = w ? priv : (own || priv);
                end
                e.err   = !ok;
                e.rdata = (ok && !w) ? m_data[a] : '0;
                sb.push_back(e);
                if (ok && w) begin
                    m_data[a] = d;
                    if (m_state[a] == 0) begin
                        m_owner[a] = t;
                        m_state[a] = lk ? 2 : 1;
                    end else if (m_state[a] == 1) begin
                        if (lk) m_state[a] = 2;
                    end else if (!lk) begin
                        m_state[a] = 0;
                        m_owner[a] = '0;
                    end
                end
            end
            if (clr) begin
                m_cnt = (v && !ok) ? 1 : 0;
                m_irq = (v && !ok) && (THRESH <= 1);
            end else if (v && !ok) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt >= THRESH) m_irq = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            got = sb.pop_front();
            chk("rsp_valid", 64'(bus.rsp_valid), 64'(1'b1));
            chk("rsp_err",   64'(bus.rsp_err),   64'(got.err));
            chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(got.rdata));
        end else begin
            chk("rsp_idle", 64'(bus.rsp_valid), 64'(1'b0));
        end
        for (int i = 0; i < NREGS; i++) lk_exp[i] = (m_state[i] == 2);
        chk("lock_status", 64'(bus.lock_status), 64'(lk_exp));
        chk("viol_count",  64'(bus.viol_count),  64'(m_cnt));
        chk("viol_irq",    64'(bus.viol_irq),    64'(m_irq));
    endtask

    task automatic rd(input logic [2:0] a, input logic [TW-1:0] t);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, a, t, '0, 1'b0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [TW-1:0] t,
                      input logic [DW-1:0] d, input logic lk);
        cycle(1'b0, 1'b1, 1'b1, lk, a, t, d, 1'b0);
    endtask

    task automatic idle(input logic clr);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, clr);
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_lock  = 1'b0;
        bus.req_addr  = '0;
        bus.req_tid   = '0;
        bus.req_wdata = '0;
        bus.viol_clr  = 1'b0;
        model_reset();

        // Reset, with a request presented during reset that must be dropped
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 4'd3, 32'hFFFF_0000, 1'b0);
        idle(1'b0);

        // Ownership claim and foreign read reject
        wr(3'd2, 4'd3, 32'hA5A5_A5A5, 1'b0);
        rd(3'd2, 4'd5);
        rd(3'd2, 4'd3);

        // Lock, owner write reject, owner read, privileged release
        wr(3'd2, 4'd3, 32'hA5A5_A5A5, 1'b1);
        wr(3'd2, 4'd3, 32'hDEAD_BEEF, 1'b0);
        rd(3'd2, 4'd3);
        rd(3'd2, 4'd9);
        wr(3'd2, 4'd0, 32'h0000_0001, 1'b0);
        rd(3'd2, 4'd7);

        // Privileged write while OWNED keeps the owner
        wr(3'd1, 4'd6, 32'h1111_2222, 1'b0);
        wr(3'd1, 4'd0, 32'h3333_4444, 1'b0);
        rd(3'd1, 4'd6);
        rd(3'd1, 4'd0);
        wr(3'd1, 4'd0, 32'h5555_6666, 1'b1);
        wr(3'd1, 4'd0, 32'h7777_8888, 1'b1);
        rd(3'd1, 4'd6);

        // Threshold, saturation and clear
        idle(1'b1);
        for (int i = 0; i < 4; i++) rd(3'd7, 4'd2);
        for (int i = 0; i < 300; i++) rd(3'd6, 4'd1);
        idle(1'b1);
        idle(1'b0);

        // Clear with a same-cycle reject
        for (int i = 0; i < 5; i++) rd(3'd7, 4'd4);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 3'd7, 4'd4, '0, 1'b1);
        idle(1'b0);

        // Back-to-back write then read of reg0
        wr(3'd0, 4'd4, 32'h1234_5678, 1'b0);
        rd(3'd0, 4'd4);
        wr(3'd5, 4'd8, 32'hCAFE_F00D, 1'b0);
        rd(3'd5, 4'd8);
        rd(3'd5, 4'd2);

        // Reset right after a write, with a request in the reset cycle
        wr(3'd3, 4'd6, 32'h0BAD_CAFE, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 4'd6, '0, 1'b0);
        for (int i = 0; i < NREGS; i++) rd(3'(i), 4'd9);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
